i2s_sample_capture: RTL and testbench

Downstream stage of the S/PDIF decoder. It takes the decoder's recovered I2S stream (`i2s_bck`, `i2s_ws`, `i2s_d0`) on the same system clock, deserialises it into parallel left and right PCM words, and produces a one-cycle stereo-sample strobe. It also qualifies the stream with its own frame-level lock and error detection, so audio consumers (volume, PWM, FIFO) see only complete, well-formed stereo pairs.

---
 rtl/spdif_pkg.sv | 18 +
 rtl/i2s_edge_sync.sv | 43 ++++
 rtl/i2s_sample_capture.sv | 189 ++++++++++++++++++
 tb/tb_i2s_sample_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Types and default widths shared by the S/PDIF decoder and the I2S capture stage.
package spdif_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } cap_state_e;

  localparam int SPDIF_WIDTH    = 24;
  localparam int SPDIF_MIN_BITS = 16;
  localparam int BITCNT_W       = 6;

  function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Registers the recovered I2S inputs and flags the bit-clock rising edge.
module i2s_edge_sync (
  input  logic clk,
  input  logic resetb,
  input  logic bck_i,
  input  logic ws_i,
  input  logic d0_i,
  output logic ws_o,
  output logic d0_o,
  output logic rise_o
);

  logic bck_q, bck_d;
  logic bck_q2, bck_d2;
  logic ws_q, ws_d;
  logic d0_q, d0_d;

  always_comb begin
    bck_d  = bck_i;
    ws_d   = ws_i;
    d0_d   = d0_i;
    bck_d2 = bck_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bck_q  <= 1'b0;
      bck_q2 <= 1'b0;
      ws_q   <= 1'b0;
      d0_q   <= 1'b0;
    end else begin
      bck_q  <= bck_d;
      bck_q2 <= bck_d2;
      ws_q   <= ws_d;
      d0_q   <= d0_d;
    end
  end

  assign ws_o   = ws_q;
  assign d0_o   = d0_q;
  assign rise_o = bck_q & ~bck_q2;

endmodule

// File: rtl/i2s_sample_capture.sv
// Deserialises the I2S stream into left/right PCM words with frame lock and error qualification.
//   state | meaning
//   SYNC  | no alignment; waiting for a word boundary into the left channel
//   LEFT  | accumulating a left word
//   RIGHT | accumulating a right word; a good boundary publishes the pair
module i2s_sample_capture
  import spdif_pkg::*;
#(
  parameter int WIDTH       = SPDIF_WIDTH,
  parameter int MIN_BITS    = SPDIF_MIN_BITS,
  parameter int LOCK_FRAMES = 4,
  parameter int BCK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i2s_bck,
  input  logic             i2s_ws,
  input  logic             i2s_d0,
  output logic [WIDTH-1:0] pcm_l,
  output logic [WIDTH-1:0] pcm_r,
  output logic             sample_valid,
  output logic             locked,
  output logic             frame_err
);

  localparam int TW = $clog2(BCK_TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [6:0]    WIDTH7 = 7'(WIDTH);
  localparam logic [6:0]    MIN7   = 7'(MIN_BITS);
  localparam logic [TW-1:0] TO_MAX = TW'(BCK_TIMEOUT);
  localparam logic [TW-1:0] TO_HIT = TW'(BCK_TIMEOUT - 1);
  localparam logic [GW-1:0] LF     = GW'(LOCK_FRAMES);

  logic ws_s, d0_s, rise;

  i2s_edge_sync u_edge_sync (
    .clk    (clk),
    .resetb (resetb),
    .bck_i  (i2s_bck),
    .ws_i   (i2s_ws),
    .d0_i   (i2s_d0),
    .ws_o   (ws_s),
    .d0_o   (d0_s),
    .rise_o (rise)
  );

  cap_state_e          state_q, state_d;
  logic                ws_last_q, ws_last_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]    hold_l_q, hold_l_d;
  logic [WIDTH-1:0]    pcm_l_q, pcm_l_d;
  logic [WIDTH-1:0]    pcm_r_q, pcm_r_d;
  logic [GW-1:0]       good_cnt_q, good_cnt_d;
  logic                locked_q, locked_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;

  logic             bit_kept;
  logic [WIDTH-1:0] sh_new;
  logic [6:0]       n_kept;
  logic [WIDTH-1:0] word_al;
  logic             short_word;
  logic             timeout_hit;
  logic [GW-1:0]    gc_next;
  logic             err;

  // Bits past WIDTH are dropped so the word stays MSB-justified.
  always_comb begin
    bit_kept   = ({1'b0, bitcnt_q} < WIDTH7);
    sh_new     = bit_kept ? {shreg_q[WIDTH-2:0], d0_s} : shreg_q;
    n_kept     = bit_kept ? ({1'b0, bitcnt_q} + 7'd1) : WIDTH7;
    word_al    = sh_new << (WIDTH7 - n_kept);
    short_word = (({1'b0, bitcnt_q} + 7'd1) < MIN7);
    gc_next    = (good_cnt_q == LF) ? good_cnt_q : good_cnt_q + 1'b1;
  end

  // A rise in the threshold cycle clears the counter, so it never fires alongside a boundary.
  always_comb begin
    timeout_hit = !rise && (to_cnt_q == TO_HIT);
    if (rise)                  to_cnt_d = '0;
    else if (to_cnt_q == TO_MAX) to_cnt_d = to_cnt_q;
    else                       to_cnt_d = to_cnt_q + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    ws_last_d      = ws_last_q;
    shreg_d        = shreg_q;
    bitcnt_d       = bitcnt_q;
    hold_l_d       = hold_l_q;
    pcm_l_d        = pcm_l_q;
    pcm_r_d        = pcm_r_q;
    good_cnt_d     = good_cnt_q;
    locked_d       = locked_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    err            = 1'b0;

    if (rise) begin
      if (ws_s == ws_last_q) begin
        shreg_d  = sh_new;
        bitcnt_d = bitcnt_inc(bitcnt_q);
      end else begin
        shreg_d   = '0;
        bitcnt_d  = '0;
        ws_last_d = ws_s;
        unique case (state_q)
          SYNC: begin
            if (!ws_s) state_d = LEFT;
          end
          LEFT: begin
            if (short_word) begin
              err = 1'b1;
            end else begin
              hold_l_d = word_al;
              state_d  = RIGHT;
            end
          end
          RIGHT: begin
            if (short_word) begin
              err = 1'b1;
            end else begin
              pcm_l_d    = hold_l_q;
              pcm_r_d    = word_al;
              good_cnt_d = gc_next;
              if (locked_q || gc_next == LF) begin
                locked_d       = 1'b1;
                sample_valid_d = 1'b1;
              end
              state_d = LEFT;
            end
          end
          default: state_d = SYNC;
        endcase
      end
    end else if (timeout_hit) begin
      err = 1'b1;
    end

    if (err) begin
      frame_err_d = 1'b1;
      good_cnt_d  = '0;
      locked_d    = 1'b0;
      shreg_d     = '0;
      bitcnt_d    = '0;
      hold_l_d    = '0;
      state_d     = SYNC;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= SYNC;
      ws_last_q      <= 1'b0;
      shreg_q        <= '0;
      bitcnt_q       <= '0;
      hold_l_q       <= '0;
      pcm_l_q        <= '0;
      pcm_r_q        <= '0;
      good_cnt_q     <= '0;
      locked_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      ws_last_q      <= ws_last_d;
      shreg_q        <= shreg_d;
      bitcnt_q       <= bitcnt_d;
      hold_l_q       <= hold_l_d;
      pcm_l_q        <= pcm_l_d;
      pcm_r_q        <= pcm_r_d;
      good_cnt_q     <= good_cnt_d;
      locked_q       <= locked_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign pcm_l        = pcm_l_q;
  assign pcm_r        = pcm_r_q;
  assign sample_valid = sample_valid_q;
  assign locked       = locked_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_sample_capture.sv
// Scoreboard bench for i2s_sample_capture: expected stereo pairs are queued as frames are sent.
module tb_i2s_sample_capture;

  localparam int WIDTH = 24;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic i2s_bck = 1'b0;
  logic i2s_ws = 1'b0;
  logic i2s_d0 = 1'b0;
  logic [WIDTH-1:0] pcm_l, pcm_r;
  logic sample_valid, locked, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fe_cnt = 0;
  int sv_cnt = 0;
  int fe_last_cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_sample_capture #(
    .WIDTH(WIDTH), .MIN_BITS(16), .LOCK_FRAMES(4), .BCK_TIMEOUT(255)
  ) dut (
    .clk(clk), .resetb(resetb), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws), .i2s_d0(i2s_d0),
    .pcm_l(pcm_l), .pcm_r(pcm_r), .sample_valid(sample_valid), .locked(locked),
    .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_valid || frame_err)
      check("sv_fe_excl", {63'd0, sample_valid & frame_err}, 64'd0);
    if (sample_valid) begin
      sv_cnt++;
      check("sv_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("pcm_l", {40'd0, pcm_l}, {40'd0, exp_e[47:24]});
        check("pcm_r", {40'd0, pcm_r}, {40'd0, exp_e[23:0]});
      end
    end
    if (frame_err) begin
      fe_cnt++;
      fe_last_cyc = cyc;
    end
  end

  // One bit: 4 clk low then 4 clk high; ws/d0 change only while bck is low.
  task automatic send_bit(input logic ws, input logic d);
    @(negedge clk);
    i2s_bck = 1'b0;
    i2s_ws  = ws;
    i2s_d0  = d;
    repeat (4) @(negedge clk);
    i2s_bck  = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(negedge clk);
  endtask

  // The final (LSB) bit goes out with the next channel's ws, as the capture expects.
  task automatic send_word(input logic ch, input logic nxt, input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++)
      send_bit((i == n - 1) ? nxt : ch, data[n-1-i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
    send_word(1'b0, 1'b1, l, nl);
    send_word(1'b1, 1'b0, r, nr);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pcm_l"}, {40'd0, pcm_l}, 64'd0);
    check({tag, "_pcm_r"}, {40'd0, pcm_r}, 64'd0);
    check({tag, "_sv"}, {63'd0, sample_valid}, 64'd0);
    check({tag, "_locked"}, {63'd0, locked}, 64'd0);
    check({tag, "_ferr"}, {63'd0, frame_err}, 64'd0);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, sv0;
    logic [23:0] lv, rv;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    resetb = 1'b1;

    // Clean stream: 3-bit right-channel tail aligns the capture before frame 1.
    send_word(1'b1, 1'b0, 32'd0, 3);
    fe0 = fe_cnt; sv0 = sv_cnt;
    for (int f = 1; f <= 6; f++) begin
      if (f >= 4) exp_q.push_back({24'h123456, 24'hABCDEF});
      send_frame({24'h123456, 8'h00}, {24'hABCDEF, 8'h00}, 32, 32);
      check($sformatf("clean_lock_f%0d", f), {63'd0, locked}, {63'd0, f >= 4});
    end
    check("clean_ferr", fe_cnt - fe0, 0);
    check("clean_sv", sv_cnt - sv0, 3);

    // 16-bit words are left-aligned into the 24-bit outputs.
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back({24'h800100, 24'h7FFF00});
      send_frame(32'h0000_8001, 32'h0000_7FFF, 16, 16);
    end

    // Short right word after lock.
    fe0 = fe_cnt; sv0 = sv_cnt;
    send_word(1'b0, 1'b1, {24'h123456, 8'h00}, 32);
    send_word(1'b1, 1'b0, 32'h0000_02AA, 10);
    check("short_ferr", fe_cnt - fe0, 1);
    check("short_locked", {63'd0, locked}, 64'd0);
    check("short_pcm_l", {40'd0, pcm_l}, 64'h800100);
    check("short_pcm_r", {40'd0, pcm_r}, 64'h7FFF00);
    // The frame after the error is consumed re-aligning; the next four relock.
    for (int k = 1; k <= 5; k++) begin
      lv = 24'h100000 + 24'(k);
      rv = 24'h200000 + 24'(k);
      if (k == 5) exp_q.push_back({lv, rv});
      send_frame({lv, 8'h00}, {rv, 8'h00}, 32, 32);
      check($sformatf("relock_k%0d", k), {63'd0, locked}, {63'd0, k == 5});
    end
    check("short_sv", sv_cnt - sv0, 1);
    check("short_ferr_total", fe_cnt - fe0, 1);

    // Timeout: bck parked low for 300 clk.
    fe0 = fe_cnt;
    @(negedge clk);
    i2s_bck = 1'b0;
    repeat (300) @(negedge clk);
    check("to_ferr", fe_cnt - fe0, 1);
    // bck driven high at cycle P is registered at P+1; error lands 255 clk after P+2.
    check("to_latency", fe_last_cyc - rise_cyc, 257);
    check("to_locked", {63'd0, locked}, 64'd0);
    check("to_pcm_l", {40'd0, pcm_l}, 64'h100005);
    check("to_pcm_r", {40'd0, pcm_r}, 64'h200005);

    // Startup in the middle of a right word.
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    fe0 = fe_cnt; sv0 = sv_cnt;
    send_word(1'b1, 1'b0, 32'h0000_05A5, 12);
    check("start_pcm_l", {40'd0, pcm_l}, 64'd0);
    check("start_pcm_r", {40'd0, pcm_r}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      lv = 24'h300000 + 24'(k);
      rv = 24'h400000 + 24'(k);
      if (k == 4) exp_q.push_back({lv, rv});
      send_frame({lv, 8'h00}, {rv, 8'h00}, 32, 32);
      check($sformatf("start_lock_k%0d", k), {63'd0, locked}, {63'd0, k == 4});
    end
    check("start_sv", sv_cnt - sv0, 1);

    // Async reset part-way through a left word.
    for (int i = 0; i < 12; i++) send_bit(1'b0, i[0]);
    @(negedge clk);
    i2s_bck = 1'b0;
    resetb  = 1'b0;
    #1;
    check_outputs_zero("async");
    @(negedge clk);
    resetb = 1'b1;
    sv0 = sv_cnt;
    send_word(1'b1, 1'b0, 32'd0, 3);
    for (int k = 1; k <= 4; k++) begin
      lv = 24'h500000 + 24'(k);
      rv = 24'h600000 + 24'(k);
      if (k == 4) exp_q.push_back({lv, rv});
      send_frame({lv, 8'h00}, {rv, 8'h00}, 32, 32);
      check($sformatf("arst_lock_k%0d", k), {63'd0, locked}, {63'd0, k == 4});
    end
    check("arst_sv", sv_cnt - sv0, 1);
    check("arst_ferr", fe_cnt - fe0, 0);

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
